// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: checks decoded instruction fields, packs them into 32-bit
// decoder words and writes them to sequential imem word addresses.
`ifndef INSTR_ENC_DEFS
`define INSTR_ENC_DEFS
`define ALUR 4'd0
`define ALUI 4'd1
`define CMPR 4'd2
`define CMPI 4'd3
`define BRANCH 4'd4
`define LOAD 4'd5
`define STORE 4'd6
`define JAL 4'd7
`define INSTR_ADD 4'd0
`define INSTR_SUB 4'd1
`define INSTR_AND 4'd2
`define INSTR_OR 4'd3
`define INSTR_XOR 4'd4
`define INSTR_NAND 4'd5
`define INSTR_NOR 4'd6
`define INSTR_XNOR 4'd7
`define INSTR_MVHI 4'd8
`define INSTR_F 4'd0
`define INSTR_EQ 4'd1
`define INSTR_LT 4'd2
`define INSTR_LTE 4'd3
`define INSTR_T 4'd4
`define INSTR_NE 4'd5
`define INSTR_GTE 4'd6
`define INSTR_GT 4'd7
`define INSTR_B_LAST 4'd13
`endif

module instr_encoder_loader #(
    parameter int ADDR_W     = 32,
    parameter int MAX_INSTRS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_fn,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [15:0]       count
);
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, ERR} state_t;
    localparam logic [15:0] MAX_CNT = 16'(MAX_INSTRS);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic we_q, we_d, last_q, last_d;
    logic [15:0] count_q, count_d;
    logic [1:0] err_q, err_d;
    logic op_ok, fn_ok, is_r, is_alu, is_cmp;
    logic [31:0] word;
    always_comb begin
        is_r   = in_opcode == `ALUR || in_opcode == `CMPR;
        is_alu = in_opcode == `ALUR || in_opcode == `ALUI;
        is_cmp = in_opcode == `CMPR || in_opcode == `CMPI;
        word   = {in_fn, in_opcode, is_r ? {12'b0, in_rs2} : in_imm, in_rs1, in_rd};
        op_ok  = in_opcode <= `JAL;
        fn_ok  = is_alu ? in_fn <= `INSTR_MVHI :
                 is_cmp ? in_fn <= `INSTR_GT :
                 in_opcode == `BRANCH ? in_fn <= `INSTR_B_LAST : in_fn == 4'd0;
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                addr_d  = base_addr;
                count_d = '0;
                we_d    = 1'b0;
                err_d   = base_addr[1:0] != 2'b00 ? 2'd3 : 2'd0;
                state_d = base_addr[1:0] != 2'b00 ? ERR : LOAD;
            end
            LOAD: if (we_q) begin
                if (imem_ack) begin
                    we_d    = 1'b0;
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = count_q + 16'd1;
                    state_d = last_q ? DONE : LOAD;
                end
            end else if (in_valid) begin
                err_d   = !op_ok ? 2'd1 : !fn_ok ? 2'd2 : count_q == MAX_CNT ? 2'd3 : 2'd0;
                state_d = (!op_ok || !fn_ok || count_q == MAX_CNT) ? ERR : LOAD;
                we_d    = op_ok && fn_ok && count_q != MAX_CNT;
                wdata_d = we_d ? word : wdata_q;
                last_d  = we_d ? in_last : last_q;
            end
            // Finishes a write that was already issued before the error was raised.
            DRAIN: if (!we_q || imem_ack) begin
                we_d    = 1'b0;
                addr_d  = we_q ? addr_q + ADDR_W'(4) : addr_q;
                count_d = we_q ? count_q + 16'd1 : count_q;
                state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
    assign in_ready   = state_q == LOAD && !we_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = state_q == LOAD || state_q == DRAIN;
    assign done       = state_q == DONE;
    assign error      = state_q == ERR;
    assign err_code   = err_q;
    assign count      = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table vectors, hand sequences and random sessions
// checked against a rule-level model of the loader.
module tb_instr_encoder_loader;
    localparam int MAXI = 4;
    localparam logic [3:0] OP_ALUR = 4'd0, OP_ALUI = 4'd1, OP_CMPR = 4'd2, OP_CMPI = 4'd3;
    localparam logic [3:0] OP_BR = 4'd4, OP_LOAD = 4'd5, OP_STORE = 4'd6, OP_JAL = 4'd7;
    localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_MVHI = 4'd8, F_GT = 4'd7;
    logic clk = 1'b0, reset, start, in_valid, in_ready, in_last, imem_we, imem_ack;
    logic busy, done, error;
    logic [31:0] base_addr, imem_addr, imem_wdata;
    logic [3:0] in_fn, in_opcode, in_rd, in_rs1, in_rs2;
    logic [15:0] in_imm, count;
    logic [1:0] err_code;
    int n_chk = 0, n_fail = 0;
    typedef struct packed {logic [3:0] fn, op, rd, rs1, rs2; logic [15:0] imm;} tup_t;
    typedef struct packed {tup_t t; logic [1:0] err; logic [31:0] word;} vec_t;
    vec_t vt [12];

    instr_encoder_loader #(.ADDR_W(32), .MAX_INSTRS(MAXI)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .count(count));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [1:0] model_err(tup_t t, int cnt);
        int fmax;
        if (t.op > 4'd7) return 2'd1;
        fmax = (t.op <= 4'd1) ? 8 : (t.op <= 4'd3) ? 7 : (t.op == 4'd4) ? 13 : 0;
        if (int'(t.fn) > fmax) return 2'd2;
        if (cnt >= MAXI) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_word(tup_t t);
        logic [15:0] mid;
        mid = (t.op == OP_ALUR || t.op == OP_CMPR) ? {12'h000, t.rs2} : t.imm;
        return {t.fn, t.op, mid, t.rs1, t.rd};
    endfunction

    task automatic junk_fields();
        {in_fn, in_opcode, in_rd, in_rs1, in_rs2} = 20'($urandom);
        in_imm  = 16'($urandom);
        in_last = 1'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 0);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_flags"}, {29'b0, busy, done, error}, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_err"}, 32'(err_code), 0);
        chk({tag, "_count"}, 32'(count), 0);
    endtask

    task automatic begin_session(input logic [31:0] base);
        start = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
        base_addr = $urandom;
        if (base[1:0] != 2'b00) begin
            chk("misalign_error", 32'(error), 1);
            chk("misalign_code", 32'(err_code), 3);
            chk("misalign_busy", 32'(busy), 0);
        end else begin
            chk("start_state", {28'b0, busy, done, error, in_ready}, 32'b1001);
            chk("start_count", 32'(count), 0);
        end
    endtask

    task automatic send(input tup_t t, input logic last, input logic [1:0] eerr, input logic [31:0] eword,
                        input int ecnt, input logic [31:0] eaddr, input int dly, output logic ok);
        chk("ready_before", 32'(in_ready), 1);
        {in_fn, in_opcode, in_rd, in_rs1, in_rs2, in_imm} = t;
        in_last = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'($urandom);
        junk_fields();
        ok = 1'b0;
        if (eerr != 2'd0) begin
            in_valid = 1'b0;
            chk("err_flag", 32'(error), 1);
            chk("err_code", 32'(err_code), 32'(eerr));
            chk("err_no_write", 32'(imem_we), 0);
            chk("err_count", 32'(count), ecnt);
            return;
        end
        chk("we", 32'(imem_we), 1);
        chk("addr", imem_addr, eaddr);
        chk("wdata", imem_wdata, eword);
        chk("ready_pending", 32'(in_ready), 0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("we_hold", 32'(imem_we), 1);
            chk("wdata_hold", imem_wdata, eword);
            chk("addr_hold", imem_addr, eaddr);
            chk("ready_hold", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("we_drop", 32'(imem_we), 0);
        chk("count_inc", 32'(count), ecnt + 1);
        chk("done_after", 32'(done), 32'(last));
        chk("busy_after", 32'(busy), 32'(!last));
        ok = 1'b1;
    endtask

    initial begin
        logic ok;
        logic [31:0] base;
        tup_t t;
        int n, cnt;
        vt[0]  = '{'{F_ADD, OP_ALUI, 4'h3, 4'h2, 4'h0, 16'hFFFC}, 2'd0, 32'h01FFFC23};
        vt[1]  = '{'{F_SUB, OP_ALUR, 4'h7, 4'h6, 4'h5, 16'hABCD}, 2'd0, 32'h10000567};
        vt[2]  = '{'{F_MVHI, OP_CMPI, 4'h1, 4'h1, 4'h1, 16'h0001}, 2'd2, 32'h0};
        vt[3]  = '{'{4'h0, 4'h9, 4'h1, 4'h1, 4'h1, 16'h0001}, 2'd1, 32'h0};
        vt[4]  = '{'{4'hD, OP_BR, 4'hB, 4'hA, 4'h9, 16'h1234}, 2'd0, 32'hD41234AB};
        vt[5]  = '{'{4'hE, OP_BR, 4'h1, 4'h1, 4'h1, 16'h0000}, 2'd2, 32'h0};
        vt[6]  = '{'{4'h0, OP_LOAD, 4'h2, 4'h1, 4'hF, 16'h0010}, 2'd0, 32'h05001012};
        vt[7]  = '{'{4'h1, OP_STORE, 4'h2, 4'h1, 4'h0, 16'h0010}, 2'd2, 32'h0};
        vt[8]  = '{'{4'h0, OP_JAL, 4'hF, 4'h0, 4'h3, 16'h8000}, 2'd0, 32'h0780000F};
        vt[9]  = '{'{F_GT, OP_CMPR, 4'h5, 4'h4, 4'h3, 16'hFFFF}, 2'd0, 32'h72000345};
        vt[10] = '{'{4'h9, OP_ALUR, 4'h1, 4'h1, 4'h1, 16'h0000}, 2'd2, 32'h0};
        vt[11] = '{'{4'h0, 4'hF, 4'h1, 4'h1, 4'h1, 16'h0000}, 2'd1, 32'h0};
        reset = 1'b1; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0; imem_ack = 1'b0;
        junk_fields();
        tick(); tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();
        check_reset_vals("idle");
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("idle_ack_ignored", 32'(count), 0);

        for (int i = 0; i < 12; i++) begin
            begin_session(32'h100);
            send(vt[i].t, 1'b1, vt[i].err, vt[i].word, 0, 32'h100, $urandom_range(0, 2), ok);
        end

        begin_session(32'h100);
        for (int i = 0; i < 3; i++) begin
            t = '{F_ADD, OP_ALUI, 4'(i), 4'(i + 1), 4'h0, 16'(i * 3)};
            send(t, i == 2, 2'd0, model_word(t), i, 32'h100 + 32'(4 * i), 3, ok);
        end
        chk("stream_count", 32'(count), 3);
        in_valid = 1'b1; imem_ack = 1'b1;
        tick(); tick();
        in_valid = 1'b0; imem_ack = 1'b0;
        chk("done_sticky", {28'b0, done, imem_we, in_ready, busy}, 32'b1000);
        chk("done_count_hold", 32'(count), 3);

        begin_session(32'h100);
        t = '{F_ADD, OP_ALUI, 4'h1, 4'h2, 4'h0, 16'h0004};
        send(t, 1'b0, 2'd0, model_word(t), 0, 32'h100, 0, ok);
        t = '{F_MVHI, OP_CMPI, 4'h1, 4'h2, 4'h0, 16'h0004};
        send(t, 1'b0, 2'd2, 32'h0, 1, 32'h104, 0, ok);

        begin_session(32'h40);
        for (int i = 0; i <= MAXI; i++) begin
            t = '{4'h0, OP_JAL, 4'(i), 4'h0, 4'h0, 16'(i)};
            send(t, 1'b0, model_err(t, i), model_word(t), i, 32'h40 + 32'(4 * i), 1, ok);
        end
        chk("overflow_count", 32'(count), MAXI);

        begin_session(32'h102);
        chk("misalign_ready", 32'(in_ready), 0);

        begin_session(32'h200);
        t = '{F_SUB, OP_ALUR, 4'h1, 4'h2, 4'h3, 16'h0};
        send(t, 1'b0, 2'd0, model_word(t), 0, 32'h200, 0, ok);
        start = 1'b1; base_addr = 32'h300;
        tick();
        start = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("start_in_load_busy", 32'(busy), 1);
        chk("load_stray_ack", 32'(count), 1);
        send(t, 1'b1, 2'd0, model_word(t), 1, 32'h204, 0, ok);

        begin_session(32'hFFFF_FFFC);
        t = '{4'h0, OP_LOAD, 4'h1, 4'h2, 4'h3, 16'h7};
        send(t, 1'b0, 2'd0, model_word(t), 0, 32'hFFFF_FFFC, 0, ok);
        send(t, 1'b1, 2'd0, model_word(t), 1, 32'h0, 0, ok);

        begin_session(32'h100);
        {in_fn, in_opcode, in_rd, in_rs1, in_rs2, in_imm} = {F_ADD, OP_ALUI, 24'h123456};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("abort_we_before", 32'(imem_we), 1);
        reset = 1'b1; imem_ack = 1'b1;
        tick();
        reset = 1'b0; imem_ack = 1'b0;
        check_reset_vals("abort");

        for (int s = 0; s < 40; s++) begin
            base = ($urandom_range(0, 7) == 0) ? 32'h10 | 32'($urandom_range(1, 3)) :
                   ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : $urandom & 32'hFFFF_FFFC;
            begin_session(base);
            if (base[1:0] != 2'b00) continue;
            n = $urandom_range(1, 6);
            cnt = 0;
            for (int i = 0; i < n; i++) begin
                t.op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
                t.fn  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (t.op >= OP_LOAD) ? 4'h0 : 4'($urandom_range(0, 7));
                {t.rd, t.rs1, t.rs2} = 12'($urandom);
                t.imm = 16'($urandom);
                send(t, i == n - 1, model_err(t, cnt), model_word(t), cnt, base + 32'(4 * cnt),
                     $urandom_range(0, 3), ok);
                if (!ok) break;
                cnt++;
                junk_fields();
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
